// File: rtl/famicom_bus_pkg.sv
// Shared CPU-bus constants and the sprite DMA state type for the 2A03 bus slice.
package famicom_bus_pkg;

    localparam logic [15:0] APU_OAMDMA   = 16'h4014;
    localparam logic [15:0] PPU_OAMDATA  = 16'h2004;
    localparam int unsigned OAM_XFER_LEN = 256;

    typedef enum logic [2:0] {
        IDLE,
        HALT,
        ALIGN,
        GET,
        PUT
    } dma_state_t;

endpackage

// File: rtl/oam_dma.sv
// 2A03 sprite DMA: a $4014 write stalls the CPU and copies page $XX00-$XXFF into $2004.
// dma_busy is the bus-arbiter select between the CPU's external address and dma_addr.
module oam_dma
    import famicom_bus_pkg::*;
#(
    parameter logic [15:0] DMA_REG_ADDR  = APU_OAMDMA,
    parameter logic [15:0] OAM_DATA_ADDR = PPU_OAMDATA,
    parameter int unsigned XFER_LEN      = OAM_XFER_LEN
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_we,
    input  logic [7:0]  dma_rdata,
    output logic        cpu_rdy,
    output logic        dma_busy,
    output logic [15:0] dma_addr,
    output logic        dma_re,
    output logic        dma_we,
    output logic [7:0]  dma_wdata
);

    localparam int unsigned IDX_W = $clog2(XFER_LEN);

    dma_state_t       r_state;
    dma_state_t       w_state_next;
    logic [7:0]       r_page;
    logic [IDX_W-1:0] r_index;
    logic             r_parity;

    logic             w_trigger;
    logic             w_last;
    logic [15:0]      w_src_addr;

    assign w_trigger  = cpu_we && (cpu_addr == DMA_REG_ADDR);
    assign w_last     = (r_index == IDX_W'(XFER_LEN - 1));
    // Source never carries into the page byte: the index simply wraps.
    assign w_src_addr = {r_page, 8'(r_index)};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_page   <= '0;
            r_index  <= '0;
            r_parity <= 1'b0;
        end else begin
            r_parity <= ~r_parity;
            if (r_state == IDLE && w_trigger) begin
                r_page  <= cpu_wdata;
                r_index <= '0;
            end else if (r_state == PUT) begin
                r_index <= r_index + IDX_W'(1);
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (w_trigger) w_state_next = HALT;
            // An odd HALT cycle lets GET fall straight onto the next even cycle.
            HALT:    w_state_next = r_parity ? GET : ALIGN;
            ALIGN:   w_state_next = GET;
            GET:     w_state_next = PUT;
            PUT:     w_state_next = w_last ? IDLE : GET;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        cpu_rdy   = 1'b0;
        dma_busy  = 1'b1;
        dma_addr  = 16'h0000;
        dma_re    = 1'b0;
        dma_we    = 1'b0;
        dma_wdata = 8'h00;
        unique case (r_state)
            IDLE: begin
                cpu_rdy  = 1'b1;
                dma_busy = 1'b0;
            end
            HALT, ALIGN: begin
            end
            GET: begin
                dma_re   = 1'b1;
                dma_addr = w_src_addr;
            end
            PUT: begin
                dma_we    = 1'b1;
                dma_addr  = OAM_DATA_ADDR;
                dma_wdata = dma_rdata;
            end
            default: begin
                cpu_rdy  = 1'b1;
                dma_busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_oam_dma.sv
// Randomised scoreboard bench for oam_dma with a transfer-level reference model.
module tb_oam_dma;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] cpu_addr = 16'h0000;
    logic [7:0]  cpu_wdata = 8'h00;
    logic        cpu_we = 1'b0;
    logic [7:0]  dma_rdata = 8'h00;
    logic        cpu_rdy;
    logic        dma_busy;
    logic [15:0] dma_addr;
    logic        dma_re;
    logic        dma_we;
    logic [7:0]  dma_wdata;

    oam_dma dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_we    (cpu_we),
        .dma_rdata (dma_rdata),
        .cpu_rdy   (cpu_rdy),
        .dma_busy  (dma_busy),
        .dma_addr  (dma_addr),
        .dma_re    (dma_re),
        .dma_we    (dma_we),
        .dma_wdata (dma_wdata)
    );

    always #5 clk = ~clk;

    logic [7:0]  mem [65536];
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    int          idle_from = 0;
    int          last_trig = -1;
    int          run = 0;
    logic        mon_busy;
    logic [15:0] q_get [$];
    logic [23:0] q_put [$];
    int          q_stall [$];

    // Cycle index since reset; its LSB is the even/odd CPU cycle.
    always @(posedge clk) begin
        cyc       <= reset ? 0 : cyc + 1;
        dma_rdata <= dma_re ? mem[dma_addr] : 8'($urandom);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string nm);
        total++;
        bad++;
        $display("FAIL %s: got event expected none (cycle %0d)", nm, cyc);
    endtask

    // Monitor: checks every cycle against the queued expectations.
    always @(negedge clk) begin
        mon_busy = (cyc > last_trig) && (cyc < idle_from);
        chk("cpu_rdy", {31'b0, cpu_rdy}, {31'b0, !mon_busy});
        chk("dma_busy", {31'b0, dma_busy}, {31'b0, mon_busy});
        if (dma_re) begin
            if (q_get.size() == 0) fail_now("get_unexpected");
            else begin
                chk("get_addr", {16'b0, dma_addr}, {16'b0, q_get.pop_front()});
                chk("get_even", cyc & 1, 0);
            end
        end
        if (dma_we) begin
            if (q_put.size() == 0) fail_now("put_unexpected");
            else begin
                logic [23:0] e;
                e = q_put.pop_front();
                chk("put_addr", {16'b0, dma_addr}, {16'b0, e[23:8]});
                chk("put_data", {24'b0, dma_wdata}, {24'b0, e[7:0]});
            end
        end
        if (!dma_re && !dma_we) begin
            chk("quiet_addr", {16'b0, dma_addr}, 0);
            chk("quiet_wdata", {24'b0, dma_wdata}, 0);
        end
        if (!cpu_rdy) run++;
        else if (run > 0) begin
            if (q_stall.size() == 0) fail_now("stall_unexpected");
            else chk("stall_len", run, q_stall.pop_front());
            run = 0;
        end
        if (reset) begin
            q_get.delete();
            q_put.delete();
            q_stall.delete();
            run = 0;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Drives one CPU bus cycle; an accepted trigger enqueues the whole transfer.
    task automatic bus(input logic [15:0] a, input logic [7:0] d, input logic we);
        int st;
        cpu_addr  = a;
        cpu_wdata = d;
        cpu_we    = we;
        if (we && a == 16'h4014 && cyc >= idle_from && !reset) begin
            st = ((cyc & 1) != 0) ? 514 : 513;
            q_stall.push_back(st);
            for (int i = 0; i < 256; i++) begin
                q_get.push_back({d, 8'(i)});
                q_put.push_back({16'h2004, mem[{d, 8'(i)}]});
            end
            last_trig = cyc;
            idle_from = cyc + st + 1;
        end
        step();
        cpu_we = 1'b0;
    endtask

    task automatic wait_idle();
        while (cyc < idle_from) step();
    endtask

    task automatic check_reset_outputs(input string tag);
        @(negedge clk);
        chk({tag, "_rdy"}, {31'b0, cpu_rdy}, 1);
        chk({tag, "_busy"}, {31'b0, dma_busy}, 0);
        chk({tag, "_re"}, {31'b0, dma_re}, 0);
        chk({tag, "_we"}, {31'b0, dma_we}, 0);
        chk({tag, "_addr"}, {16'b0, dma_addr}, 0);
        chk({tag, "_wdata"}, {24'b0, dma_wdata}, 0);
    endtask

    initial begin
        int target;
        int guard;
        logic [7:0] pg;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < 256; i++) mem[16'h0300 + i] = 8'(i) ^ 8'hA5;

        step();
        check_reset_outputs("reset");
        step();
        step();
        reset = 1'b0;
        step();

        // Even-cycle trigger, then odd-cycle trigger.
        if ((cyc & 1) != 0) step();
        bus(16'h4014, 8'h02, 1'b1);
        repeat (10) step();
        bus(16'h4014, 8'h07, 1'b1);
        wait_idle();
        if ((cyc & 1) == 0) step();
        bus(16'h4014, 8'h02, 1'b1);
        wait_idle();

        // Data integrity on page 3, then ignored accesses while idle.
        bus(16'h4014, 8'h03, 1'b1);
        wait_idle();
        bus(16'h4015, 8'h05, 1'b1);
        bus(16'h4014, 8'hAA, 1'b0);
        repeat (4) step();

        // Reset on the PUT of index 0x40, then a fresh transfer.
        bus(16'h4014, 8'h5A, 1'b1);
        target = last_trig + (((last_trig & 1) != 0) ? 4 : 3) + 2 * 8'h40;
        while (cyc < target) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        idle_from = 0;
        last_trig = -1;
        check_reset_outputs("midreset");
        step();
        bus(16'h4014, 8'h02, 1'b1);
        wait_idle();

        // Back-to-back: retrigger on the first idle cycle.
        bus(16'h4014, 8'h03, 1'b1);
        wait_idle();
        bus(16'h4014, 8'h11, 1'b1);
        wait_idle();

        // Random pages, random alignment and random bus noise during transfers.
        for (int it = 0; it < 6; it++) begin
            repeat ($urandom_range(0, 3)) step();
            pg = 8'($urandom);
            bus(16'h4014, pg, 1'b1);
            for (int n = 0; n < 20; n++) begin
                case ($urandom_range(0, 3))
                    0:       bus(16'h4014, 8'($urandom), 1'($urandom));
                    1:       bus(16'h4015, 8'($urandom), 1'($urandom));
                    2:       bus(16'h2004, 8'($urandom), 1'($urandom));
                    default: bus(16'($urandom), 8'($urandom), 1'($urandom));
                endcase
            end
            wait_idle();
        end

        guard = 0;
        while ((q_put.size() != 0 || q_stall.size() != 0) && guard < 3000) begin
            step();
            guard++;
        end
        if (guard >= 3000) fail_now("drain_timeout");
        repeat (3) step();
        chk("left_get", q_get.size(), 0);
        chk("left_put", q_put.size(), 0);
        chk("left_stall", q_stall.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
